// File: rtl/frost32_lsu_bridge_pkg.sv
// rtl/frost32_lsu_bridge_pkg.sv - shared types and helpers for the Frost32 load/store bridge
//
// Contents:
//   lsu_state_e              bridge FSM states (IDLE / ACCESS / RESPOND)
//   data_inout_access_size_e CPU access size; FULL means the full bus width (32 or 64 bit)
//   lsu_fault_e              fault cause, kept internally for debug visibility
//   LSU_TIMEOUT              default wait-state limit for the optional bus timeout
//   lsu_check_align()        classifies a request as good, misaligned or bad-size
package frost32_lsu_bridge_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_ACCESS  = 2'd1,
        LSU_RESPOND = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        DIAS_FULL = 2'd0,
        DIAS_HALF = 2'd1,
        DIAS_BYTE = 2'd2,
        DIAS_BAD  = 2'd3
    } data_inout_access_size_e;

    typedef enum logic [1:0] {
        LSU_FAULT_NONE       = 2'd0,
        LSU_FAULT_MISALIGNED = 2'd1,
        LSU_FAULT_BAD_SIZE   = 2'd2,
        LSU_FAULT_TIMEOUT    = 2'd3
    } lsu_fault_e;

    localparam int LSU_TIMEOUT = 255;

    // offset is the lane offset zero-extended to 3 bits, so a non-zero value
    // always means "not on a full-width boundary" for both 32- and 64-bit buses.
    function automatic lsu_fault_e lsu_check_align(input data_inout_access_size_e size,
                                                   input logic [2:0]              offset);
        lsu_fault_e result;
        result = LSU_FAULT_NONE;
        case (size)
            DIAS_BAD:  result = LSU_FAULT_BAD_SIZE;
            DIAS_HALF: if (offset[0]) result = LSU_FAULT_MISALIGNED;
            DIAS_FULL: if (offset != 3'd0) result = LSU_FAULT_MISALIGNED;
            default:   result = LSU_FAULT_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/frost32_lsu_lane_align.sv
// rtl/frost32_lsu_lane_align.sv - combinational lane steering for stores and loads
//
// Purely combinational. Stores: byte enables from size/offset and lane-replicated
// write data. Loads: shift the bus word down by the lane offset, keep 8/16/full
// bits and zero- or sign-extend to DATA_WIDTH (little-endian lanes).
//
// Ports:
//   size        access size (FULL/HALF/BYTE; BAD treated as FULL, never reaches the bus)
//   offset      byte lane offset within the bus word
//   sign_extend 1 = sign-extend loads, 0 = zero-extend
//   store_data  right-justified CPU store data
//   bus_rdata   raw memory read word
//   byte_en     active-high byte enables
//   bus_wdata   replicated store data
//   load_data   extracted and extended load result
module frost32_lsu_lane_align
    import frost32_lsu_bridge_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    localparam int LANE_BITS  = $clog2(DATA_WIDTH / 8)
) (
    input  data_inout_access_size_e   size,
    input  logic [LANE_BITS-1:0]      offset,
    input  logic                      sign_extend,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic [DATA_WIDTH-1:0]     bus_rdata,
    output logic [DATA_WIDTH/8-1:0]   byte_en,
    output logic [DATA_WIDTH-1:0]     bus_wdata,
    output logic [DATA_WIDTH-1:0]     load_data
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted   = bus_rdata >> {offset, 3'b000};
        byte_en   = '1;
        bus_wdata = store_data;
        load_data = shifted;
        case (size)
            DIAS_BYTE: begin
                byte_en   = {{(NUM_BYTES - 1){1'b0}}, 1'b1} << offset;
                bus_wdata = {NUM_BYTES{store_data[7:0]}};
                load_data = {{(DATA_WIDTH - 8){sign_extend & shifted[7]}}, shifted[7:0]};
            end
            DIAS_HALF: begin
                byte_en   = {{(NUM_BYTES - 2){1'b0}}, 2'b11} << offset;
                bus_wdata = {(NUM_BYTES / 2){store_data[15:0]}};
                load_data = {{(DATA_WIDTH - 16){sign_extend & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                byte_en   = '1;
                bus_wdata = store_data;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/frost32_lsu_bridge.sv
// rtl/frost32_lsu_bridge.sv - Frost32 CPU data port to word-wide memory bus bridge
//
// One CPU request at a time: alignment check, req/ack bus handshake with byte
// enables, lane-extracted and extended load data, fault reporting with cpu_done.
// Optional bus timeout: define FROST32_LSU_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cpu_req .. cpu_sign_extend  CPU request (sampled only in IDLE)
//   cpu_busy, cpu_done, cpu_fault, cpu_rdata  CPU response
//   mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en  bus request (held until ack)
//   mem_ack, mem_rdata      bus completion and read data (same cycle)
module frost32_lsu_bridge
    import frost32_lsu_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic                    cpu_access_type,
    input  logic [1:0]              cpu_access_size,
    input  logic                    cpu_sign_extend,
    output logic                    cpu_busy,
    output logic                    cpu_done,
    output logic                    cpu_fault,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);

    lsu_state_e              state_q, state_d;
    lsu_fault_e              fault_q, fault_d;
    data_inout_access_size_e size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    we_q, we_d;
    logic                    sext_q, sext_d;

`ifdef FROST32_LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    logic [DATA_WIDTH/8-1:0] align_be;
    logic [DATA_WIDTH-1:0]   align_wdata;
    logic [DATA_WIDTH-1:0]   align_load;

    frost32_lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .size        (size_q),
        .offset      (addr_q[LANE_BITS-1:0]),
        .sign_extend (sext_q),
        .store_data  (wdata_q),
        .bus_rdata   (mem_rdata),
        .byte_en     (align_be),
        .bus_wdata   (align_wdata),
        .load_data   (align_load)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        sext_d  = sext_q;
`ifdef FROST32_LSU_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (cpu_req) begin
                    size_d  = data_inout_access_size_e'(cpu_access_size);
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_access_type;
                    sext_d  = cpu_sign_extend;
                    fault_d = lsu_check_align(data_inout_access_size_e'(cpu_access_size),
                                              3'(cpu_addr[LANE_BITS-1:0]));
                    // Faulting requests still spend one busy cycle here with the
                    // bus gated off, so they answer with the same latency as a
                    // zero-wait access.
                    state_d = LSU_ACCESS;
`ifdef FROST32_LSU_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            LSU_ACCESS: begin
                if (fault_q != LSU_FAULT_NONE) begin
                    state_d = LSU_RESPOND;
                end else if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = align_load;
                    end
                    state_d = LSU_RESPOND;
                end
`ifdef FROST32_LSU_TIMEOUT_EN
                // Ack on the limit cycle wins because it is tested first.
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    fault_d = LSU_FAULT_TIMEOUT;
                    state_d = LSU_RESPOND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            LSU_RESPOND: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LSU_IDLE;
            fault_q <= LSU_FAULT_NONE;
            size_q  <= DIAS_FULL;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
`ifdef FROST32_LSU_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            sext_q  <= sext_d;
`ifdef FROST32_LSU_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Bus fields are forced to zero outside an active bus cycle so idle/reset
    // outputs are all-zero even though a FULL size decodes to all byte enables.
    assign cpu_busy    = (state_q == LSU_ACCESS);
    assign cpu_done    = (state_q == LSU_RESPOND);
    assign cpu_fault   = cpu_done && (fault_q != LSU_FAULT_NONE);
    assign cpu_rdata   = rdata_q;
    assign mem_req     = (state_q == LSU_ACCESS) && (fault_q == LSU_FAULT_NONE);
    assign mem_we      = mem_req & we_q;
    assign mem_addr    = mem_req ? {addr_q[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}} : '0;
    assign mem_wdata   = mem_req ? align_wdata : '0;
    assign mem_byte_en = mem_req ? align_be : '0;

endmodule

// File: tb/tb_frost32_lsu_bridge.sv
// tb/tb_frost32_lsu_bridge.sv - scoreboard bench for frost32_lsu_bridge (32- and 64-bit)
module tb_frost32_lsu_bridge;

    typedef struct {
        logic        fault;
        logic [63:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb32[$];
    exp_t sb64[$];

    // 32-bit instance
    logic        a_req = 0, a_type = 0, a_sext = 0, a_ack = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_mrdata = 0;
    logic [1:0]  a_size = 0;
    logic        a_busy, a_done, a_fault, a_mreq, a_mwe;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [3:0]  a_be;

    // 64-bit instance
    logic        b_req = 0, b_type = 0, b_sext = 0, b_ack = 0;
    logic [31:0] b_addr = 0;
    logic [63:0] b_wdata = 0, b_mrdata = 0;
    logic [1:0]  b_size = 0;
    logic        b_busy, b_done, b_fault, b_mreq, b_mwe;
    logic [63:0] b_rdata, b_mwdata;
    logic [31:0] b_maddr;
    logic [7:0]  b_be;

    frost32_lsu_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut32 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(a_req), .cpu_addr(a_addr), .cpu_wdata(a_wdata),
        .cpu_access_type(a_type), .cpu_access_size(a_size), .cpu_sign_extend(a_sext),
        .cpu_busy(a_busy), .cpu_done(a_done), .cpu_fault(a_fault), .cpu_rdata(a_rdata),
        .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_byte_en(a_be), .mem_ack(a_ack), .mem_rdata(a_mrdata)
    );

    frost32_lsu_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(b_req), .cpu_addr(b_addr), .cpu_wdata(b_wdata),
        .cpu_access_type(b_type), .cpu_access_size(b_size), .cpu_sign_extend(b_sext),
        .cpu_busy(b_busy), .cpu_done(b_done), .cpu_fault(b_fault), .cpu_rdata(b_rdata),
        .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_byte_en(b_be), .mem_ack(b_ack), .mem_rdata(b_mrdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitors: pop on cpu_done, and flag any done with nothing pending.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sb32.size() == 0) begin
                check("done32_unexpected", a_done, 1'b0);
            end else if (a_done) begin
                exp_t e;
                e = sb32.pop_front();
                check("fault32", a_fault, e.fault);
                check("rdata32", a_rdata, e.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (sb64.size() == 0) begin
                check("done64_unexpected", b_done, 1'b0);
            end else if (b_done) begin
                exp_t e;
                e = sb64.pop_front();
                check("fault64", b_fault, e.fault);
                check("rdata64", b_rdata, e.rdata);
            end
        end
    end

    // bus=1: a bus cycle is expected for waits+1 cycles; ack_en drives mem_ack in the last one.
    task automatic access32(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                            input logic [1:0] size, input logic sext, input logic [31:0] rd,
                            input int waits, input logic bus, input logic ack_en,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic exp_fault,
                            input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        a_req = 1; a_addr = addr; a_wdata = wdata; a_type = we; a_size = size; a_sext = sext;
        e.fault = exp_fault;
        e.rdata = 64'(exp_rdata);
        sb32.push_back(e);
        @(negedge clk);
        a_req = 0;
        check("busy32", a_busy, 1'b1);
        if (!bus) begin
            check("no_mem_req32", a_mreq, 1'b0);
            @(negedge clk);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                check("mem_req32", a_mreq, 1'b1);
                check("mem_addr32", a_maddr, exp_addr);
                check("byte_en32", a_be, exp_be);
                check("mem_we32", a_mwe, we);
                if (we) check("mem_wdata32", a_mwdata, exp_wd);
                if (i == waits && ack_en) begin
                    a_ack = 1; a_mrdata = rd;
                end
                @(negedge clk);
                a_ack = 0;
            end
        end
        check("done32", a_done, 1'b1);
        check("req_dropped32", a_mreq, 1'b0);
        check("busy_respond32", a_busy, 1'b0);
    endtask

    task automatic access64(input logic [31:0] addr, input logic [63:0] wdata, input logic we,
                            input logic [1:0] size, input logic sext, input logic [63:0] rd,
                            input logic [31:0] exp_addr, input logic [7:0] exp_be,
                            input logic [63:0] exp_wd, input logic [63:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        b_req = 1; b_addr = addr; b_wdata = wdata; b_type = we; b_size = size; b_sext = sext;
        e.fault = 1'b0;
        e.rdata = exp_rdata;
        sb64.push_back(e);
        @(negedge clk);
        b_req = 0;
        check("mem_req64", b_mreq, 1'b1);
        check("mem_addr64", b_maddr, exp_addr);
        check("byte_en64", b_be, exp_be);
        if (we) check("mem_wdata64", b_mwdata, exp_wd);
        b_ack = 1; b_mrdata = rd;
        @(negedge clk);
        b_ack = 0;
        check("done64", b_done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_mem_req", a_mreq, 1'b0);
        check("rst_byte_en", a_be, 4'h0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_byte_en64", b_be, 8'h00);
        @(negedge clk);
        reset_n = 1;

        //       addr          wdata         we    sz    sx    mem_rdata     w  bus   ack   exp_addr      be       exp_wd        flt   exp_rdata
        access32(32'h0000_0103, 32'h0,        1'b0, 2'd2, 1'b1, 32'h80AA_BBCC, 0, 1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80);
        access32(32'h0000_0202, 32'h1234,     1'b1, 2'd1, 1'b0, 32'h0,         3, 1'b1, 1'b1, 32'h0000_0200, 4'b1100, 32'h1234_1234, 1'b0, 32'hFFFF_FF80);
        access32(32'h0000_0006, 32'h0,        1'b0, 2'd0, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'hFFFF_FF80);
        access32(32'h0000_0000, 32'h0,        1'b0, 2'd3, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'hFFFF_FF80);
        access32(32'h0000_0001, 32'h0,        1'b0, 2'd1, 1'b1, 32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 32'hFFFF_FF80);
        access32(32'h0000_0012, 32'h0,        1'b0, 2'd1, 1'b0, 32'h8001_7F00, 0, 1'b1, 1'b1, 32'h0000_0010, 4'b1100, 32'h0,        1'b0, 32'h0000_8001);
        access32(32'h0000_0010, 32'h0,        1'b0, 2'd1, 1'b1, 32'h1234_9ABC, 0, 1'b1, 1'b1, 32'h0000_0010, 4'b0011, 32'h0,        1'b0, 32'hFFFF_9ABC);
        access32(32'h0000_0040, 32'h0,        1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF, 1, 1'b1, 1'b1, 32'h0000_0040, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF);
        access32(32'h0000_0051, 32'h0000_00A5, 1'b1, 2'd2, 1'b0, 32'h0,        0, 1'b1, 1'b1, 32'h0000_0050, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF);
        access32(32'h0000_0060, 32'hCAFE_F00D, 1'b1, 2'd0, 1'b0, 32'h0,        0, 1'b1, 1'b1, 32'h0000_0060, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF);
        access32(32'h0000_0021, 32'h0,        1'b0, 2'd2, 1'b0, 32'h0000_9900, 2, 1'b1, 1'b1, 32'h0000_0020, 4'b0010, 32'h0,        1'b0, 32'h0000_0099);
`ifdef FROST32_LSU_TIMEOUT_EN
        // No ack: four request cycles, then a timeout fault; ack on the 4th cycle succeeds.
        access32(32'h0000_0070, 32'h0,        1'b0, 2'd0, 1'b0, 32'h0,         3, 1'b1, 1'b0, 32'h0000_0070, 4'b1111, 32'h0,        1'b1, 32'h0000_0099);
        access32(32'h0000_0070, 32'h0,        1'b0, 2'd0, 1'b0, 32'h5555_AAAA, 3, 1'b1, 1'b1, 32'h0000_0070, 4'b1111, 32'h0,        1'b0, 32'h5555_AAAA);
`else
        // Without the timeout feature a long wait simply completes.
        access32(32'h0000_0070, 32'h0,        1'b0, 2'd0, 1'b0, 32'h5555_AAAA, 6, 1'b1, 1'b1, 32'h0000_0070, 4'b1111, 32'h0,        1'b0, 32'h5555_AAAA);
`endif

        // Reset in the middle of an access.
        @(negedge clk);
        a_req = 1; a_addr = 32'h80; a_type = 0; a_size = 2'd0;
        @(negedge clk);
        a_req = 0;
        check("mid_mem_req", a_mreq, 1'b1);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        check("async_mem_req", a_mreq, 1'b0);
        check("async_busy", a_busy, 1'b0);
        check("async_rdata", a_rdata, 32'h0);
        sb32.delete();
        @(negedge clk);
        reset_n = 1;
        repeat (3) @(negedge clk);
        access32(32'h0000_0084, 32'h0,        1'b0, 2'd0, 1'b0, 32'h0BAD_F00D, 0, 1'b1, 1'b1, 32'h0000_0084, 4'b1111, 32'h0,        1'b0, 32'h0BAD_F00D);

        //       addr          wdata                   we    sz    sx    mem_rdata               exp_addr      be     exp_wd                  exp_rdata
        access64(32'h0000_000E, 64'h0,                  1'b0, 2'd1, 1'b0, 64'hBEEF_0000_0000_0000, 32'h0000_0008, 8'hC0, 64'h0,                  64'h0000_0000_0000_BEEF);
        access64(32'h0000_000F, 64'h0,                  1'b0, 2'd2, 1'b1, 64'h80FF_FFFF_FFFF_FFFF, 32'h0000_0008, 8'h80, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80);
        access64(32'h0000_000B, 64'h5A,                 1'b1, 2'd2, 1'b0, 64'h0,                   32'h0000_0008, 8'h08, 64'h5A5A_5A5A_5A5A_5A5A, 64'hFFFF_FFFF_FFFF_FF80);
        access64(32'h0000_0018, 64'h0,                  1'b0, 2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 32'h0000_0018, 8'hFF, 64'h0,                  64'h0123_4567_89AB_CDEF);

        repeat (3) @(negedge clk);
        check("sb32_drained", 64'(sb32.size()), 64'd0);
        check("sb64_drained", 64'(sb64.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
